// File: rtl/im_loader_pkg.sv
// im_loader_pkg: state encodings and width defaults shared by the
// boot loader, the instruction memory and the core top level.
package im_loader_pkg;

    localparam int DATA_SIZE      = 32;
    localparam int MEM_SIZE       = 10;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] S_LEN   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

endpackage

// File: rtl/im_loader.sv
// im_loader: boot-time IM program loader. Takes a byte stream made of a
// length word N, N data words and an XOR checksum word, all sent MSB first.
// It writes each data word into the IM and holds the core in reset until
// the checksum matches.
// Ports: clk, rst (sync, active-high); rx_valid/rx_data/rx_ready (byte
// stream); IM_address/IM_enable/IM_write/IM_read/IMin (IM write port);
// cpu_reset, busy, done, err (status).
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DataSize = DATA_SIZE,
    parameter int MemSize  = MEM_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic [MemSize-1:0]  IM_address,
    output logic                IM_enable,
    output logic                IM_write,
    output logic                IM_read,
    output logic [DataSize-1:0] IMin,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                err
);

    logic [2:0]          state, state_n;
    logic [1:0]          cnt, cnt_n;
    logic [DataSize-1:0] asm_word, asm_n;
    logic [DataSize-1:0] word_n;
    logic [DataSize-1:0] xor_acc, xor_n;
    // One extra bit so that N = 2^MemSize is representable.
    logic [MemSize:0]    addr, addr_n;
    logic [MemSize:0]    len, len_n;
    logic                accept, last, we_n;

    assign IM_read = 1'b0;

    assign accept = rx_valid & rx_ready;
    assign word_n = {asm_word[DataSize-9:0], rx_data};
    assign last   = accept && (cnt == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        asm_n   = asm_word;
        xor_n   = xor_acc;
        addr_n  = addr;
        len_n   = len;
        we_n    = 1'b0;
        if (accept) begin
            asm_n = word_n;
            cnt_n = cnt + 2'd1;
        end
        case (state)
            S_LEN: begin
                if (last) begin
                    if (word_n > (DataSize'(1) << MemSize)) begin
                        state_n = S_ERR;
                    end else if (word_n == '0) begin
                        state_n = S_CHK;
                    end else begin
                        state_n = S_DATA;
                        len_n   = word_n[MemSize:0];
                        addr_n  = '0;
                        xor_n   = '0;
                    end
                end
            end
            S_DATA: begin
                if (last) begin
                    state_n = S_WRITE;
                    we_n    = 1'b1;
                end
            end
            S_WRITE: begin
                // asm_word still holds the word being strobed into the IM.
                xor_n = xor_acc ^ asm_word;
                if (addr == len - 1'b1) begin
                    state_n = S_CHK;
                end else begin
                    state_n = S_DATA;
                    addr_n  = addr + 1'b1;
                end
            end
            S_CHK: begin
                if (last) begin
                    state_n = (word_n == xor_acc) ? S_DONE : S_ERR;
                end
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN;
            cnt        <= '0;
            asm_word   <= '0;
            xor_acc    <= '0;
            addr       <= '0;
            len        <= '0;
            rx_ready   <= 1'b0;
            IM_address <= '0;
            IM_enable  <= 1'b0;
            IM_write   <= 1'b0;
            IMin       <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            asm_word  <= asm_n;
            xor_acc   <= xor_n;
            addr      <= addr_n;
            len       <= len_n;
            // Outputs follow the next state so every one is a flop.
            rx_ready  <= (state_n == S_LEN) || (state_n == S_DATA) ||
                         (state_n == S_CHK);
            IM_enable <= we_n;
            IM_write  <= we_n;
            if (we_n) begin
                IM_address <= addr[MemSize-1:0];
                IMin       <= word_n;
            end
            cpu_reset <= (state_n != S_DONE);
            busy      <= (state_n != S_DONE);
            done      <= (state_n == S_DONE);
            err       <= (state_n == S_ERR);
        end
    end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader for the instruction memory: the write-side counterpart of the processor's fetch path. It accepts a byte stream (length header, instruction words, XOR checksum), writes each word into the IM through its write port (`enable_im`/`enable_write`/`IMin`), and holds the processor core in reset until the image is complete and verified. It sits beside `top`; the system level muxes the IM address/control onto the loader while `busy` is high.

## Interface
- `DataSize`, 32, IM word width (fixed at 32 for byte assembly)
- `MemSize`, 10, IM address width; capacity 2^MemSize words

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx_valid`  in  1  byte available on `rx_data`
- `rx_data`  in  8  stream byte
- `rx_ready`  out  1  loader accepts a byte this cycle
- `IM_address`  out  MemSize  IM write address
- `IM_enable`  out  1  to IM `enable_im`
- `IM_write`  out  1  to IM `enable_write`
- `IM_read`  out  1  to IM `enable_fetch`; constant 0
- `IMin`  out  DataSize  write data to IM
- `cpu_reset`  out  1  active-high reset to `top`
- `busy`  out  1  loader owns the IM bus
- `done`  out  1  image loaded and checksum matched
- `err`  out  1  length overflow or checksum mismatch

## Operation
- Stream format: length word N, then N data words, then checksum word C = XOR of all N data words. Each word is 4 bytes, most-significant byte first (first byte -> bits [31:24]).
- Byte accepted on a rising edge with `rx_valid & rx_ready`; a byte counter (0..3) shifts it into a 32-bit assembly register.
- States: LEN, DATA, WRITE, CHK, DONE, ERR.
  - LEN: assemble N. N > 2^MemSize -> ERR. N == 0 -> CHK. Else -> DATA, addr = 0, xor_acc = 0.
  - DATA: assemble word; on 4th byte -> WRITE.
  - WRITE: one-cycle strobe, `IM_enable` = `IM_write` = 1, `IM_address` = addr, `IMin` = word; xor_acc ^= word. If addr == N-1 -> CHK, else addr++ -> DATA.
  - CHK: assemble C; on 4th byte, C == xor_acc -> DONE, else -> ERR.
  - DONE / ERR: terminal until `rst`; `rx_ready` = 0, IM strobes 0.
- `rx_ready` = 1 only in LEN, DATA, CHK. `busy` = 1 in every state except DONE.
- `cpu_reset` = 1 in all states except DONE; in ERR the core stays held.
- Address counter is MemSize+1 bits internally so N = 2^MemSize is legal (last address 2^MemSize-1, no wrap).

## Timing
- All outputs registered. Reset values: `rx_ready` 0, `IM_address` 0, `IM_enable` 0, `IM_write` 0, `IM_read` 0, `IMin` 0, `cpu_reset` 1, `busy` 1, `done` 0, `err` 0, state LEN.
- `rx_ready` rises the first cycle after `rst` deasserts.
- 4th byte of a data word accepted at edge k: cycle k+1 is the WRITE strobe with `rx_ready` = 0 (IM captures at end of k+1); `rx_ready` = 1 again in cycle k+2. Minimum 5 cycles per data word.
- 4th checksum byte at edge k: `done` (or `err`) = 1 and `cpu_reset` = 0 (or stays 1) in cycle k+1; `busy` = 0 with `done`.
- `rx_valid` gaps of any length stall without state change; bytes offered while `rx_ready` = 0 are not consumed.
- `rst` mid-load: next cycle all outputs at reset values, byte counter/addr/xor_acc cleared, restart from LEN; IM contents already written are not cleared.

## Structure
- Shared package: state encoding constants, `BYTES_PER_WORD` = 4, width defaults (DataSize, MemSize) shared with IM/top.
- Single module; no sub-module needed (byte assembler is a few lines inside).

## Test plan
- N = 3, words 0x00000000 (NOP), 0x440000C8, 0x50100064, C = XOR -> IM mem_data[0..2] hold those words, exactly 3 write strobes, `done` = 1 and `cpu_reset` = 0 one cycle after last checksum byte.
- N = 0, C = 0 -> no write strobe, `done` = 1 after 8 bytes.
- N = 1025 (MemSize 10) -> `err` = 1 after 4th length byte, `rx_ready` = 0, `cpu_reset` stays 1.
- N = 2, C off by one bit -> both words written, `err` = 1, `done` = 0, `cpu_reset` = 1.
- Same 3-word image with random 0–7 cycle `rx_valid` gaps -> identical IM contents and final state.
- `rst` pulsed after 2nd data word written -> restart; reload of a different 2-word image ends `done` with mem_data[0..1] = new words.
